spi_master: RTL and testbench

//  SPI mode-0 (CPOL=0, CPHA=0) master; initiator end of the link served by spi_slave.

---
 rtl/spi_master.sv | 149 ++++++++++++++
 tb/tb_spi_master.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI mode-0 master: shifts one word out on mosi (MSB first) while capturing miso.
// sclk and cs are generated from clk; words can be chained under one cs assertion.
module spi_master #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned CS_SETUP   = 2,
    parameter int unsigned CS_HOLD    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  cont,
    output logic                  ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  done,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic                  cs
);

    localparam int unsigned CntW = 16;
    localparam int unsigned BitW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CntW-1:0] DivLast   = CntW'(CLK_DIV - 1);
    localparam logic [CntW-1:0] SetupLast = CntW'(CS_SETUP - 1);
    // Hold runs one cycle past CS_HOLD: the first hold cycle is the falling-edge cycle itself.
    localparam logic [CntW-1:0] HoldLast  = CntW'(CS_HOLD);
    localparam logic [BitW-1:0] BitLast   = BitW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {StIdle, StSetup, StLow, StHigh, StHold, StArmed} state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [BitW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]   tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0]   rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
    logic                    done_q, done_d;
    logic                    sclk_q, sclk_d;
    logic                    mosi_q, mosi_d;
    logic                    cs_q, cs_d;
    logic                    ready_q, ready_d;

    logic load, low_end, high_end, last_bit;

    assign load     = start && (state_q == StIdle || state_q == StArmed);
    assign low_end  = (state_q == StLow)  && (cnt_q == DivLast);
    assign high_end = (state_q == StHigh) && (cnt_q == DivLast);
    assign last_bit = (bit_cnt_q == BitLast);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StSetup;
            StSetup: if (cnt_q == SetupLast) state_d = StLow;
            StLow:   if (low_end) state_d = StHigh;
            StHigh: begin
                if (high_end) begin
                    if (!last_bit)  state_d = StLow;
                    else if (cont)  state_d = StArmed;
                    else            state_d = StHold;
                end
            end
            StArmed: begin
                if (start)      state_d = StLow;
                else if (!cont) state_d = StHold;
            end
            StHold:  if (cnt_q == HoldLast) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Next values of counters, shift registers and registered outputs
    always_comb begin
        cnt_d      = (state_d != state_q) ? '0 : cnt_q + CntW'(1);
        bit_cnt_d  = bit_cnt_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        done_d     = 1'b0;
        if (load) begin
            tx_shift_d = tx_data;
            bit_cnt_d  = '0;
        end
        if (low_end) begin
            rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], miso};
        end
        if (high_end) begin
            tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
            if (last_bit) begin
                rx_data_d = rx_shift_q;
                done_d    = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + BitW'(1);
            end
        end
        cs_d    = (state_d == StIdle);
        sclk_d  = (state_d == StHigh);
        mosi_d  = (state_d == StIdle) ? 1'b0 : tx_shift_d[DATA_WIDTH-1];
        ready_d = (state_d == StIdle) || (state_d == StArmed);
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            done_q     <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_q       <= 1'b1;
            ready_q    <= 1'b1;
        end else begin
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            done_q     <= done_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_q       <= cs_d;
            ready_q    <= ready_d;
        end
    end

    assign ready   = ready_q;
    assign rx_data = rx_data_q;
    assign done    = done_q;
    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign cs      = cs_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: scoreboard of expected words and done cycles.
module tb_spi_master;

    localparam int DW  = 8;
    localparam int DIV = 4;
    localparam int SET = 2;
    localparam int HLD = 2;
    localparam int WORD_CYC = 2 * DW * DIV;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          cont = 1'b0;
    logic          ready, done, sclk, mosi, miso, cs;
    logic [DW-1:0] rx_data;
    logic [1:0]    miso_mode = 2'd0;  // 0: loopback, 1: tied high, 2: tied low

    assign miso = (miso_mode == 2'd0) ? mosi : (miso_mode == 2'd1);

    spi_master #(.DATA_WIDTH(DW), .CLK_DIV(DIV), .CS_SETUP(SET), .CS_HOLD(HLD)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .tx_data (tx_data),
        .cont    (cont),
        .ready   (ready),
        .rx_data (rx_data),
        .done    (done),
        .sclk    (sclk),
        .mosi    (mosi),
        .miso    (miso),
        .cs      (cs)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard
    logic [DW-1:0] exp_data_q[$];
    int            exp_cyc_q[$];

    // Monitor state, written only by the monitor
    int   rises = 0, done_cnt = 0, cs_rises = 0, mosi_hi = 0;
    int   bad_bus = 0, spurious = 0;
    int   cs_fall_cyc = 0, cs_rise_cyc = 0;
    logic sclk_p = 1'b0, cs_p = 1'b1;

    always @(negedge clk) begin
        if (!reset) begin
            if (sclk && !sclk_p) rises++;
            if (!cs && cs_p) cs_fall_cyc = cyc;
            if (cs && !cs_p) begin
                cs_rise_cyc = cyc;
                cs_rises++;
            end
            if (cs && (sclk || mosi)) bad_bus++;
            if ((cs != cs_p) && (sclk != sclk_p)) bad_bus++;
            if (mosi) mosi_hi++;
            if (done) begin
                done_cnt++;
                if (exp_data_q.size() == 0) begin
                    spurious++;
                end else begin
                    check("rx_data", 32'(rx_data), 32'(exp_data_q.pop_front()));
                    check("done_cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
                end
            end
        end
        sclk_p = sclk;
        cs_p   = cs;
    end

    int c0 = 0;
    int done_base = 0;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] data, input logic c, input bit armed);
        tick();
        start   = 1'b1;
        tx_data = data;
        cont    = c;
        c0      = cyc;
        done_base = done_cnt;
        exp_data_q.push_back((miso_mode == 2'd0) ? data :
                             (miso_mode == 2'd1) ? {DW{1'b1}} : {DW{1'b0}});
        exp_cyc_q.push_back(c0 + 1 + (armed ? 0 : SET) + WORD_CYC);
        tick();
        start   = 1'b0;
        tx_data = DW'($urandom);  // mid-word change must be ignored
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (done_cnt > done_base) break;
            tick();
        end
        check(tag, 32'(done_cnt > done_base), 32'd1);
    endtask

    int rb, cb, mb, db;

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_cs", 32'(cs), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rx", 32'(rx_data), 32'd0);
        check("rst_ready", 32'(ready), 32'd1);
        reset = 1'b0;
        repeat (2) tick();

        // Loopback 0xA5, single word
        rb = rises;
        send(8'hA5, 1'b0, 1'b0);
        check("busy_ready", 32'(ready), 32'd0);
        wait_done("t1_done_seen");
        repeat (6) tick();
        check("t1_rises", 32'(rises - rb), 32'd8);
        check("t1_cs_fall", 32'(cs_fall_cyc - c0), 32'd1);
        check("t1_cs_rise", 32'(cs_rise_cyc - c0), 32'd70);

        // miso tied high with zero data, then tied low with all-ones data
        miso_mode = 2'd1;
        mb = mosi_hi;
        send(8'h00, 1'b0, 1'b0);
        wait_done("t2a_done_seen");
        check("t2_mosi_low", 32'(mosi_hi - mb), 32'd0);
        repeat (6) tick();
        miso_mode = 2'd2;
        send(8'hFF, 1'b0, 1'b0);
        wait_done("t2b_done_seen");
        repeat (6) tick();
        miso_mode = 2'd0;

        // Two chained words under one cs
        rb = rises;
        send(8'h3C, 1'b1, 1'b0);
        wait_done("t3a_done_seen");
        cb = cs_rises;
        tick();
        check("t3_armed_ready", 32'(ready), 32'd1);
        check("t3_armed_cs", 32'(cs), 32'd0);
        send(8'hC3, 1'b0, 1'b1);
        wait_done("t3b_done_seen");
        check("t3_cs_stayed_low", 32'(cs_rises - cb), 32'd0);
        repeat (6) tick();
        check("t3_rises", 32'(rises - rb), 32'd16);

        // start hammered while busy
        rb = rises;
        db = done_cnt;
        send(8'h5A, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            tick();
            if (done_cnt > db) break;
            start   = 1'b1;
            tx_data = DW'($urandom);
        end
        start = 1'b0;
        repeat (8) tick();
        check("t4_one_done", 32'(done_cnt - db), 32'd1);
        check("t4_rises", 32'(rises - rb), 32'd8);
        check("t4_idle_cs", 32'(cs), 32'd1);

        // Reset in the middle of a word
        rb = rises;
        send(8'hE7, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            if (rises - rb >= 3) break;
            tick();
        end
        check("t5_reached_3rd_edge", 32'(rises - rb), 32'd3);
        reset = 1'b1;
        #1;
        check("t5_rst_cs", 32'(cs), 32'd1);
        check("t5_rst_sclk", 32'(sclk), 32'd0);
        check("t5_rst_done", 32'(done), 32'd0);
        check("t5_rst_ready", 32'(ready), 32'd1);
        exp_data_q.delete();
        exp_cyc_q.delete();
        tick();
        reset = 1'b0;
        repeat (2) tick();
        rb = rises;
        send(8'h96, 1'b0, 1'b0);
        wait_done("t5_done_seen");
        repeat (6) tick();
        check("t5_rises", 32'(rises - rb), 32'd8);

        check("bus_rules", 32'(bad_bus), 32'd0);
        check("spurious_done", 32'(spurious), 32'd0);
        check("sb_empty", 32'(exp_data_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
